cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Multi-cycle control FSM that sits directly upstream of the core datapath.
- Sequences each instruction through wait-for-IR, decode, execute and writeback.
- Drives the datapath strobes: cu_decode, cu_execute, ld_pc, branch, ld_rd, ld_apsr, ld_lr and friends.
- Consumes the datapath status outputs update_flags, write_rd, ig_ex and br_en; supports free-run and single-step.

Parameters:
- FETCH_WAIT, 1: cycles spent in S_WAIT after each PC update before IR is valid; 0 skips S_WAIT.
- RESET_HOLD, 2: cycles spent in S_RESET after rst deasserts before the first fetch.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- run  in  1  1 = free-run; 0 = halt after the current instruction.
- step  in  1  one-cycle pulse; starts exactly one instruction when in S_IDLE.
- update_flags  in  1  S bit of the decoded instruction.
- write_rd  in  1  decoded instruction writes Rd.
- ig_ex  in  1  condition failed; skip execute.
- br_en  in  1  decoded instruction is a taken branch.
- br_link  in  1  branch-with-link (L bit).
- cu_decode  out  1  decode strobe.
- cu_execute  out  1  ALU execute strobe.
- ld_pc  out  1  PC load.
- branch  out  1  PC source select: 1 = branch target, 0 = sequential increment.
- ld_lr  out  1  LR load.
- ld_rd  out  1  Rd write.
- ld_apsr  out  1  NZCV write.
- ld_sp, ld_ipsr, ld_primask  out  1 each  tied to 0 in this revision (no exception support).
- wr_en  out  1  memory write; held 0 (no store path yet).
- state  out  3  current FSM state, debug.
- instr_count  out  32  retired-instruction counter.

Behaviour:
- Clocking and reset: single clock clk; rst is synchronous, active-high, and wins over every other input.
- All outputs are registered or decoded solely from registered state; no input-to-output combinational paths.
- Reset values: state = S_RESET; instr_count = 0; all strobes 0. rst asserted mid-instruction aborts it, with no writeback strobes.
- State encodings: S_RESET = 0, S_IDLE = 1, S_WAIT = 2, S_DECODE = 3, S_EXECUTE = 4, S_WRITEBACK = 5. Codes 6 and 7 are illegal and go to S_RESET.
- S_RESET: hold counter runs for RESET_HOLD cycles, then go to S_WAIT if run, else S_IDLE.
- S_IDLE: all strobes 0. On run or step, go to S_WAIT (S_DECODE if FETCH_WAIT = 0). If both are high, run wins.
- S_WAIT: stays FETCH_WAIT cycles (internal counter), then goes to S_DECODE.
- S_DECODE: cu_decode = 1 for one cycle.
  - At the end of the cycle, latch update_flags, write_rd, br_en, br_link and ig_ex into internal registers.
  - If ig_ex = 1, go to S_WRITEBACK (execute skipped); otherwise go to S_EXECUTE.
- S_EXECUTE: cu_execute = 1 for one cycle, then go to S_WRITEBACK.
- S_WRITEBACK: one cycle.
  - ld_pc = 1 always.
  - If skipped (latched ig_ex): branch = 0, ld_rd = ld_apsr = ld_lr = 0.
  - Otherwise: ld_rd = latched write_rd; ld_apsr = latched update_flags; branch = latched br_en; ld_lr = latched br_en & br_link.
  - instr_count increments (skipped instructions count) and wraps 0xFFFFFFFF -> 0.
  - Next state: S_WAIT (or S_DECODE if FETCH_WAIT = 0) if run, else S_IDLE.
- Instruction latency: FETCH_WAIT + 3 cycles executed, FETCH_WAIT + 2 cycles skipped.
- run falling mid-instruction: the instruction completes, then the FSM enters S_IDLE.
- step outside S_IDLE is ignored; step is not queued.
- Strobes are mutually exclusive by state: cu_decode, cu_execute and ld_pc are never high together.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the state encodings S_* (3-bit localparams);
  - the default FETCH_WAIT and RESET_HOLD values.
- One natural sub-module, ctrl_wait_counter: a loadable down-counter with a done flag, reused by both S_RESET and S_WAIT.
- The FSM and output decode stay in cpu_control_unit.

Test Plan:
- Defaults, rst high 3 cycles then low with run = 1 -> state is 0 for 2 cycles, 2 for 1, then 3; cu_decode is high in the cycle after the wait.
- Non-branch ALU op (write_rd = 1, update_flags = 1, br_en = 0) -> cu_execute one cycle later; the next cycle has ld_pc = 1, branch = 0, ld_rd = 1, ld_apsr = 1; instr_count goes 0 -> 1; period is 4 cycles.
- Taken BL (br_en = 1, br_link = 1, write_rd = 0) -> in writeback ld_pc = 1, branch = 1, ld_lr = 1, ld_rd = 0.
- ig_ex = 1 in decode -> cu_execute never asserts; writeback has ld_pc = 1 with branch = ld_rd = ld_apsr = ld_lr = 0; instr_count still increments; period is 3 cycles.
- run = 0 from reset, then a step pulse -> exactly one instruction executes, the FSM returns to state 1, and instr_count = 1; a second step pulse during S_EXECUTE is ignored.
- Corner cases:
  - rst asserted during S_EXECUTE -> next cycle state = 0, all strobes 0, instr_count = 0.
  - FETCH_WAIT = 0 build -> state 2 never appears.
  - instr_count preset to 0xFFFFFFFF via a bench force -> wraps to 0 on the next retire.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings, defaults and payload types for the multi-cycle control unit.
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned COUNT_W = 32;

  localparam logic [STATE_W-1:0] S_RESET     = 3'd0;
  localparam logic [STATE_W-1:0] S_IDLE      = 3'd1;
  localparam logic [STATE_W-1:0] S_WAIT      = 3'd2;
  localparam logic [STATE_W-1:0] S_DECODE    = 3'd3;
  localparam logic [STATE_W-1:0] S_EXECUTE   = 3'd4;
  localparam logic [STATE_W-1:0] S_WRITEBACK = 3'd5;

  localparam int unsigned FETCH_WAIT_DEF = 1;
  localparam int unsigned RESET_HOLD_DEF = 2;

  typedef struct packed {
    logic update_flags;
    logic write_rd;
    logic br_en;
    logic br_link;
    logic ig_ex;
  } dec_flags_t;

  typedef struct packed {
    logic cu_decode;
    logic cu_execute;
    logic ld_pc;
    logic branch;
    logic ld_lr;
    logic ld_rd;
    logic ld_apsr;
  } strobes_t;

endpackage

// File: rtl/cpu_control_unit_if.sv
// Control-unit <-> datapath bundle: run control, decoded status in, strobes out.
interface cpu_control_unit_if;
  import cpu_ctrl_pkg::*;

  logic               run;
  logic               step;
  logic               update_flags;
  logic               write_rd;
  logic               ig_ex;
  logic               br_en;
  logic               br_link;
  logic               cu_decode;
  logic               cu_execute;
  logic               ld_pc;
  logic               branch;
  logic               ld_lr;
  logic               ld_rd;
  logic               ld_apsr;
  logic               ld_sp;
  logic               ld_ipsr;
  logic               ld_primask;
  logic               wr_en;
  logic [STATE_W-1:0] state;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    input  run, step, update_flags, write_rd, ig_ex, br_en, br_link,
    output cu_decode, cu_execute, ld_pc, branch, ld_lr, ld_rd, ld_apsr,
           ld_sp, ld_ipsr, ld_primask, wr_en, state, instr_count
  );

  modport slave (
    output run, step, update_flags, write_rd, ig_ex, br_en, br_link,
    input  cu_decode, cu_execute, ld_pc, branch, ld_lr, ld_rd, ld_apsr,
           ld_sp, ld_ipsr, ld_primask, wr_en, state, instr_count
  );

endinterface

// File: rtl/ctrl_wait_counter.sv
// Loadable down-counter; last_c flags the final cycle of a timed state.
module ctrl_wait_counter
  import cpu_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  // A timed state always lasts at least one cycle, so 0 and 1 both mean "leave now".
  assign last_c = (count <= CNT_W'(1));

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle instruction sequencer: wait-for-IR, decode, execute, writeback.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned FETCH_WAIT = FETCH_WAIT_DEF,
  parameter int unsigned RESET_HOLD = RESET_HOLD_DEF
) (
  input  logic                clk,
  input  logic                rst,
  cpu_control_unit_if.master  bus
);

  localparam logic [STATE_W-1:0] S_FETCH = (FETCH_WAIT == 0) ? S_DECODE : S_WAIT;

  logic [STATE_W-1:0] state_q, state_d;
  dec_flags_t         flags_q, flags_d;
  strobes_t           strobes_q, strobes_d;
  logic [COUNT_W-1:0] count_q;
  logic               cnt_load_c;
  logic               cnt_last_c;
  logic [CNT_W-1:0]   cnt_val_c;

  // State register; strobes are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RESET;
      flags_q   <= '0;
      strobes_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      strobes_q <= strobes_d;
      if (state_q == S_WRITEBACK) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  // Next-state and decode-flag capture.
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    case (state_q)
      S_RESET:     if (cnt_last_c) state_d = bus.run ? S_FETCH : S_IDLE;
      S_IDLE:      if (bus.run || bus.step) state_d = S_FETCH;
      S_WAIT:      if (cnt_last_c) state_d = S_DECODE;
      S_DECODE: begin
        flags_d.update_flags = bus.update_flags;
        flags_d.write_rd     = bus.write_rd;
        flags_d.br_en        = bus.br_en;
        flags_d.br_link      = bus.br_link;
        flags_d.ig_ex        = bus.ig_ex;
        state_d = bus.ig_ex ? S_WRITEBACK : S_EXECUTE;
      end
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = bus.run ? S_FETCH : S_IDLE;
      default:     state_d = S_RESET;
    endcase
  end

  // Strobes for the state being entered, so they register in step with it.
  always_comb begin
    strobes_d = '0;
    case (state_d)
      S_DECODE:    strobes_d.cu_decode  = 1'b1;
      S_EXECUTE:   strobes_d.cu_execute = 1'b1;
      S_WRITEBACK: begin
        strobes_d.ld_pc = 1'b1;
        if (!flags_d.ig_ex) begin
          strobes_d.ld_rd   = flags_d.write_rd;
          strobes_d.ld_apsr = flags_d.update_flags;
          strobes_d.branch  = flags_d.br_en;
          strobes_d.ld_lr   = flags_d.br_en & flags_d.br_link;
        end
      end
      default: strobes_d = '0;
    endcase
  end

  // The shared counter is reloaded on entry to either timed state.
  assign cnt_load_c = rst || ((state_d != state_q) &&
                              ((state_d == S_RESET) || (state_d == S_WAIT)));
  assign cnt_val_c  = (rst || (state_d == S_RESET)) ? CNT_W'(RESET_HOLD)
                                                    : CNT_W'(FETCH_WAIT);

  ctrl_wait_counter u_wait (
    .clk      (clk),
    .load     (cnt_load_c),
    .load_val (cnt_val_c),
    .last_c   (cnt_last_c)
  );

  assign bus.cu_decode   = strobes_q.cu_decode;
  assign bus.cu_execute  = strobes_q.cu_execute;
  assign bus.ld_pc       = strobes_q.ld_pc;
  assign bus.branch      = strobes_q.branch;
  assign bus.ld_lr       = strobes_q.ld_lr;
  assign bus.ld_rd       = strobes_q.ld_rd;
  assign bus.ld_apsr     = strobes_q.ld_apsr;
  assign bus.ld_sp       = 1'b0;
  assign bus.ld_ipsr     = 1'b0;
  assign bus.ld_primask  = 1'b0;
  assign bus.wr_en       = 1'b0;
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: default build plus a FETCH_WAIT = 0 build.
module tb_cpu_control_unit;
  import cpu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic step = 1'b0;
  logic update_flags = 1'b0;
  logic write_rd = 1'b0;
  logic ig_ex = 1'b0;
  logic br_en = 1'b0;
  logic br_link = 1'b0;
  logic saw_fw0_wait = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  cpu_control_unit_if if0 ();
  cpu_control_unit_if if1 ();

  assign if0.run = run;                   assign if1.run = run;
  assign if0.step = step;                 assign if1.step = step;
  assign if0.update_flags = update_flags; assign if1.update_flags = update_flags;
  assign if0.write_rd = write_rd;         assign if1.write_rd = write_rd;
  assign if0.ig_ex = ig_ex;               assign if1.ig_ex = ig_ex;
  assign if0.br_en = br_en;               assign if1.br_en = br_en;
  assign if0.br_link = br_link;           assign if1.br_link = br_link;

  cpu_control_unit dut (.clk(clk), .rst(rst), .bus(if0));
  cpu_control_unit #(.FETCH_WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  always @(negedge clk) if (if1.state == S_WAIT) saw_fw0_wait <= 1'b1;

  // {cu_decode, cu_execute, ld_pc, branch, ld_lr, ld_rd, ld_apsr}
  function automatic logic [6:0] strb();
    return {if0.cu_decode, if0.cu_execute, if0.ld_pc, if0.branch,
            if0.ld_lr, if0.ld_rd, if0.ld_apsr};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_op(input logic s, input logic w, input logic b, input logic l, input logic ig);
    update_flags = s; write_rd = w; br_en = b; br_link = l; ig_ex = ig;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1;
    repeat (3) tick();
    n_checks++; if (if0.state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", if0.state); end
    n_checks++; if (strb() !== 7'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 0000000", strb()); end
    n_checks++; if (if0.instr_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", if0.instr_count); end
    rst = 1'b0;
    tick();
    n_checks++; if (if0.state !== 3'd0) begin n_fail++; $display("FAIL hold_1: got %0d want 0", if0.state); end
    tick();
    n_checks++; if (if0.state !== 3'd2) begin n_fail++; $display("FAIL first_wait: got %0d want 2", if0.state); end
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++; if (if0.state !== 3'd3 || strb() !== 7'b1000000) begin
      n_fail++; $display("FAIL first_decode: state %0d strobes %b want 3 1000000", if0.state, strb());
    end
  endtask

  task automatic test_alu();
    tick();
    n_checks++; if (if0.state !== 3'd4 || strb() !== 7'b0100000) begin
      n_fail++; $display("FAIL alu_execute: state %0d strobes %b want 4 0100000", if0.state, strb());
    end
    tick();
    n_checks++; if (strb() !== 7'b0010011 || if0.instr_count !== 32'd0) begin
      n_fail++; $display("FAIL alu_writeback: strobes %b count %0d want 0010011 0", strb(), if0.instr_count);
    end
    n_checks++; if ({if0.ld_sp, if0.ld_ipsr, if0.ld_primask, if0.wr_en} !== 4'b0) begin
      n_fail++; $display("FAIL tied_zero: got %b want 0000", {if0.ld_sp, if0.ld_ipsr, if0.ld_primask, if0.wr_en});
    end
    tick();
    n_checks++; if (if0.state !== 3'd2 || if0.instr_count !== 32'd1) begin
      n_fail++; $display("FAIL alu_retire: state %0d count %0d want 2 1", if0.state, if0.instr_count);
    end
    set_op(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    n_checks++; if (if0.state !== 3'd3) begin n_fail++; $display("FAIL alu_period: got %0d want 3", if0.state); end
  endtask

  task automatic test_branch_link();
    tick();
    n_checks++; if (if0.state !== 3'd4) begin n_fail++; $display("FAIL bl_execute: got %0d want 4", if0.state); end
    tick();
    n_checks++; if (strb() !== 7'b0011100) begin n_fail++; $display("FAIL bl_writeback: got %b want 0011100", strb()); end
    tick();
    set_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    n_checks++; if (if0.state !== 3'd3 || if0.instr_count !== 32'd2) begin
      n_fail++; $display("FAIL bl_retire: state %0d count %0d want 3 2", if0.state, if0.instr_count);
    end
  endtask

  task automatic test_skip();
    tick();
    n_checks++; if (if0.state !== 3'd5 || strb() !== 7'b0010000) begin
      n_fail++; $display("FAIL skip_writeback: state %0d strobes %b want 5 0010000", if0.state, strb());
    end
    tick();
    n_checks++; if (if0.state !== 3'd2 || if0.instr_count !== 32'd3) begin
      n_fail++; $display("FAIL skip_retire: state %0d count %0d want 2 3", if0.state, if0.instr_count);
    end
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++; if (if0.state !== 3'd3) begin n_fail++; $display("FAIL skip_period: got %0d want 3", if0.state); end
  endtask

  task automatic test_run_drop();
    run = 1'b0;
    tick(); tick();
    n_checks++; if (strb() !== 7'b0010010) begin n_fail++; $display("FAIL drop_writeback: got %b want 0010010", strb()); end
    tick();
    n_checks++; if (if0.state !== 3'd1 || if0.instr_count !== 32'd4) begin
      n_fail++; $display("FAIL drop_idle: state %0d count %0d want 1 4", if0.state, if0.instr_count);
    end
    tick();
    n_checks++; if (if0.state !== 3'd1 || strb() !== 7'b0) begin
      n_fail++; $display("FAIL idle_hold: state %0d strobes %b want 1 0000000", if0.state, strb());
    end
  endtask

  task automatic test_step();
    rst = 1'b1; run = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick(); tick();
    n_checks++; if (if0.state !== 3'd1 || if0.instr_count !== 32'd0) begin
      n_fail++; $display("FAIL step_reset_idle: state %0d count %0d want 1 0", if0.state, if0.instr_count);
    end
    step = 1'b1; tick(); step = 1'b0;
    n_checks++; if (if0.state !== 3'd2) begin n_fail++; $display("FAIL step_start: got %0d want 2", if0.state); end
    tick(); tick();
    n_checks++; if (if0.state !== 3'd4) begin n_fail++; $display("FAIL step_execute: got %0d want 4", if0.state); end
    step = 1'b1; tick(); step = 1'b0;
    tick();
    n_checks++; if (if0.state !== 3'd1 || if0.instr_count !== 32'd1) begin
      n_fail++; $display("FAIL step_done: state %0d count %0d want 1 1", if0.state, if0.instr_count);
    end
    tick();
    n_checks++; if (if0.state !== 3'd1) begin n_fail++; $display("FAIL step_not_queued: got %0d want 1", if0.state); end
  endtask

  task automatic test_rst_mid();
    run = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (if0.state !== 3'd4) begin n_fail++; $display("FAIL mid_execute: got %0d want 4", if0.state); end
    rst = 1'b1;
    tick();
    n_checks++; if (if0.state !== 3'd0 || strb() !== 7'b0 || if0.instr_count !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset: state %0d strobes %b count %0d want 0 0000000 0", if0.state, strb(), if0.instr_count);
    end
    rst = 1'b0; run = 1'b0;
    tick(); tick();
  endtask

  task automatic test_wrap();
    force dut.count_q = 32'hFFFF_FFFF;
    tick();
    release dut.count_q;
    tick();
    n_checks++; if (if0.instr_count !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL wrap_preset: got %h want ffffffff", if0.instr_count);
    end
    step = 1'b1; tick(); step = 1'b0;
    tick(); tick(); tick();
    tick();
    n_checks++; if (if0.state !== 3'd1 || if0.instr_count !== 32'd0) begin
      n_fail++; $display("FAIL wrap_zero: state %0d count %h want 1 00000000", if0.state, if0.instr_count);
    end
  endtask

  task automatic test_fetch_wait0();
    n_checks++; if (saw_fw0_wait !== 1'b0) begin n_fail++; $display("FAIL fw0_no_wait: saw state 2, want never"); end
    n_checks++; if (if1.instr_count === 32'd0) begin n_fail++; $display("FAIL fw0_progress: count %0d want nonzero", if1.instr_count); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch_link();
    test_skip();
    test_run_drop();
    test_step();
    test_rst_mid();
    test_wrap();
    test_fetch_wait0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
